// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller behind the single-cycle CPU core: wait-stated block RAM,
// switch/LED registers and a compare timer that drives the core interrupt.
module mio_bus_ctrl #(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned TIMER_W     = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic        i_cpu_mem_w,
  input  logic        i_cpu_req,
  output logic [31:0] o_cpu_rdata,
  output logic        o_mio_ready,
  output logic        o_irq,
  output logic [9:0]  o_ram_addr,
  output logic [31:0] o_ram_wdata,
  output logic        o_ram_we,
  input  logic [31:0] i_ram_rdata,
  input  logic [15:0] i_sw,
  output logic [15:0] o_led
);

  typedef enum logic [1:0] {StIdle, StRamWait, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [3:0]         r_wait, w_wait_d;
  logic               r_wr, w_wr_d;
  logic [31:0]        r_rdata, w_rdata_d;
  logic               r_ram_we, w_ram_we_d;
  logic [15:0]        r_led, w_led_d;
  logic [TIMER_W-1:0] r_count, w_count_d;
  logic [TIMER_W-1:0] r_compare, w_compare_d;
  logic               r_pending, w_pending_d;
  logic               r_enable, w_enable_d;
  logic               r_irq;

  logic        w_is_ram, w_sel_sw, w_sel_led, w_sel_cnt, w_sel_cmp, w_sel_sts;
  logic        w_io_acc, w_io_wr, w_match;
  logic [31:0] w_io_rdata;

  assign w_is_ram  = (i_cpu_addr[31:12] == 20'h0);
  assign w_sel_sw  = (i_cpu_addr == 32'hE000_0000);
  assign w_sel_led = (i_cpu_addr == 32'hF000_0000);
  assign w_sel_cnt = (i_cpu_addr == 32'hF000_0004);
  assign w_sel_cmp = (i_cpu_addr == 32'hF000_0008);
  assign w_sel_sts = (i_cpu_addr == 32'hF000_000C);

  // IO/unmapped accesses complete on the sampling edge itself.
  assign w_io_acc = (r_state == StIdle) && i_cpu_req && !w_is_ram;
  assign w_io_wr  = w_io_acc && i_cpu_mem_w;
  assign w_match  = (r_count == r_compare) && (r_compare != '0);

  always_comb begin
    w_io_rdata = 32'h0;
    if (w_sel_sw)  w_io_rdata = {16'h0, i_sw};
    if (w_sel_led) w_io_rdata = {16'h0, r_led};
    if (w_sel_cnt) w_io_rdata = 32'(r_count);
    if (w_sel_cmp) w_io_rdata = 32'(r_compare);
    if (w_sel_sts) w_io_rdata = {30'h0, r_enable, r_pending};
  end

  always_comb begin
    w_state_d  = r_state;
    w_wait_d   = r_wait;
    w_wr_d     = r_wr;
    w_rdata_d  = r_rdata;
    w_ram_we_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cpu_req) begin
          if (w_is_ram) begin
            w_state_d  = StRamWait;
            w_wait_d   = 4'(RAM_LATENCY);
            w_wr_d     = i_cpu_mem_w;
            w_ram_we_d = i_cpu_mem_w;
          end else begin
            w_state_d = StDone;
            w_rdata_d = i_cpu_mem_w ? 32'h0 : w_io_rdata;
          end
        end
      end
      StRamWait: begin
        w_wait_d = r_wait - 4'd1;
        if (r_wait == 4'd1) begin
          w_state_d = StDone;
          w_rdata_d = r_wr ? 32'h0 : i_ram_rdata;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_led_d     = (w_io_wr && w_sel_led) ? i_cpu_wdata[15:0] : r_led;
    w_count_d   = (w_io_wr && w_sel_cnt) ? TIMER_W'(i_cpu_wdata) : r_count + TIMER_W'(1);
    w_compare_d = (w_io_wr && w_sel_cmp) ? TIMER_W'(i_cpu_wdata) : r_compare;
    w_enable_d  = (w_io_wr && w_sel_sts) ? i_cpu_wdata[1] : r_enable;
    // A match on the same edge as a write-1-clear keeps pending set.
    w_pending_d = w_match | (r_pending & ~(w_io_wr & w_sel_sts & i_cpu_wdata[0]));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_wait    <= 4'd0;
      r_wr      <= 1'b0;
      r_rdata   <= 32'h0;
      r_ram_we  <= 1'b0;
      r_led     <= 16'h0;
      r_count   <= '0;
      r_compare <= '0;
      r_pending <= 1'b0;
      r_enable  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_wait    <= w_wait_d;
      r_wr      <= w_wr_d;
      r_rdata   <= w_rdata_d;
      r_ram_we  <= w_ram_we_d;
      r_led     <= w_led_d;
      r_count   <= w_count_d;
      r_compare <= w_compare_d;
      r_pending <= w_pending_d;
      r_enable  <= w_enable_d;
      r_irq     <= r_pending & r_enable;
    end
  end

  assign o_cpu_rdata = r_rdata;
  assign o_mio_ready = (r_state == StDone);
  assign o_irq       = r_irq;
  assign o_ram_addr  = i_cpu_addr[11:2];
  assign o_ram_wdata = i_cpu_wdata;
  assign o_ram_we    = r_ram_we;
  assign o_led       = r_led;

endmodule
